// File: rtl/program_counter_stack.sv
// Program counter with a single-cycle call/return stack.
// The PC can reset, load, increment or hold. call pushes the return address
// (out+STEP) and jumps to in. ret pops the top entry back into out.
// The return stack is a circular buffer with a modulo-DEPTH top pointer, so
// DEPTH does not have to be a power of two. When a call arrives on a full
// stack, the oldest entry is overwritten. overflow and underflow are sticky
// flags that stay set until clr_err.
module program_counter_stack #(
  parameter int              WIDTH     = 16,
  parameter int              DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] STEP      = WIDTH'(1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       inc,
  input  logic                       load,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           in,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] out_reg, out_next;
  logic [DW-1:0]    depth_reg, depth_next;
  logic [PW-1:0]    top_reg, top_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  logic [WIDTH-1:0] stack_mem [DEPTH];

  logic [WIDTH-1:0] ret_addr;
  logic [PW-1:0]    top_inc, top_dec;
  logic             is_empty, is_full;
  logic             push;

  assign is_empty = (depth_reg == '0);
  assign is_full  = (depth_reg == DW'(DEPTH));
  assign ret_addr = out_reg + STEP;

  // The top pointer wraps modulo DEPTH in both directions.
  assign top_inc = (top_reg == PW'(DEPTH - 1)) ? '0 : top_reg + PW'(1);
  assign top_dec = (top_reg == '0) ? PW'(DEPTH - 1) : top_reg - PW'(1);

  // call has the highest priority. A push always lands in the slot after top.
  assign push = en & call;

  // Next-state logic. When en is set, only the highest-priority control acts.
  always_comb begin
    out_next       = out_reg;
    depth_next     = depth_reg;
    top_next       = top_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (en) begin
      // Clear first, so an error event in the same cycle still sets the flag.
      if (clr_err) begin
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
      end
      if (call) begin
        out_next = in;
        top_next = top_inc;
        if (is_full) begin
          overflow_next = 1'b1;
        end else begin
          depth_next = depth_reg + DW'(1);
        end
      end else if (ret) begin
        if (is_empty) begin
          underflow_next = 1'b1;
        end else begin
          out_next   = stack_mem[top_reg];
          top_next   = top_dec;
          depth_next = depth_reg - DW'(1);
        end
      end else if (load) begin
        out_next = in;
      end else if (inc) begin
        out_next = ret_addr;
      end
    end
  end

  // PC, stack bookkeeping and flags. Reset acts regardless of en.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_reg       <= RESET_VEC;
      depth_reg     <= '0;
      top_reg       <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      out_reg       <= out_next;
      depth_reg     <= depth_next;
      top_reg       <= top_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Each stack slot captures the return address when a push targets it.
  // The slots have no reset. After a reset, depth==0 keeps stale entries
  // from ever being popped.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      // Write slot gi on a push whose new top is gi.
      always_ff @(posedge clk) begin
        if (reset && push && (top_inc == PW'(gi))) begin
          stack_mem[gi] <= ret_addr;
        end
      end
    end
  endgenerate

  assign out       = out_reg;
  assign depth     = depth_reg;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_program_counter_stack.sv
// Testbench for program_counter_stack with WIDTH=16, DEPTH=4, STEP=1 and
// RESET_VEC=0. A queue-based reference model predicts every output.
// The bench runs the directed scenarios first, then randomized cycles.
module tb_program_counter_stack;

  localparam int W = 16;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset, en, inc, load, call, ret, clr_err;
  logic [W-1:0]  in;
  logic [W-1:0]  out;
  logic [2:0]    depth;
  logic          empty, full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [W-1:0] out_m;
  logic [W-1:0] q[$];
  logic         ovf_m, unf_m;

  program_counter_stack #(.WIDTH(W), .DEPTH(D), .RESET_VEC(16'd0), .STEP(16'd1)) dut (
    .clk(clk), .reset(reset), .en(en), .inc(inc), .load(load), .call(call),
    .ret(ret), .in(in), .clr_err(clr_err), .out(out), .depth(depth),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Apply the controls to the reference model.
  task automatic model_step(input logic r, e, c, rt, l, i, input logic [W-1:0] d, input logic cl);
    if (!r) begin
      out_m = '0;
      q.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else if (e) begin
      if (cl) begin
        ovf_m = 1'b0;
        unf_m = 1'b0;
      end
      if (c) begin
        if (q.size() == D) begin
          q.delete(0);
          ovf_m = 1'b1;
        end
        q.push_back(out_m + 16'd1);
        out_m = d;
      end else if (rt) begin
        if (q.size() == 0) unf_m = 1'b1;
        else out_m = q.pop_back();
      end else if (l) begin
        out_m = d;
      end else if (i) begin
        out_m = out_m + 16'd1;
      end
    end
  endtask

  // Drive one cycle, update the model, then compare every output.
  task automatic apply(input logic r, e, c, rt, l, i, input logic [W-1:0] d, input logic cl);
    reset = r; en = e; call = c; ret = rt; load = l; inc = i; in = d; clr_err = cl;
    @(posedge clk);
    #1;
    model_step(r, e, c, rt, l, i, d, cl);
    check_eq("out", out, out_m);
    check_eq("depth", depth, q.size());
    check_eq("empty", empty, q.size() == 0);
    check_eq("full", full, q.size() == D);
    check_eq("overflow", overflow, ovf_m);
    check_eq("underflow", underflow, unf_m);
    $display("cyc rst=%b en=%b c=%b r=%b l=%b i=%b in=%0d clr=%b -> out=%0d depth=%0d ovf=%b unf=%b",
             r, e, c, rt, l, i, d, cl, out, depth, overflow, underflow);
  endtask

  // Shorthands for the common single-control cycles.
  task automatic do_load(input logic [W-1:0] d); apply(1, 1, 0, 0, 1, 0, d, 0); endtask
  task automatic do_call(input logic [W-1:0] d); apply(1, 1, 1, 0, 0, 0, d, 0); endtask
  task automatic do_ret();                       apply(1, 1, 0, 1, 0, 0, '0, 0); endtask
  task automatic do_inc();                       apply(1, 1, 0, 0, 0, 1, '0, 0); endtask

  logic          rr, re, rc, rrt, rl, ri, rcl;
  logic [W-1:0]  rd;
  logic [W-1:0]  neg_in;

  initial begin
    reset = 1'b1; en = 1'b0; inc = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0;
    in = '0; clr_err = 1'b0;
    out_m = '0; ovf_m = 1'b0; unf_m = 1'b0;
    @(posedge clk);
    #1;

    // 1. Reset, increment, negative load, hold.
    apply(0, 1, 0, 0, 0, 0, '0, 0);
    check_eq("rst_out", out, 0);
    check_eq("rst_empty", empty, 1);
    do_inc();
    check_eq("inc1", out, 1);
    do_inc();
    check_eq("inc2", out, 2);
    neg_in = -16'd32123;
    do_load(neg_in);
    check_eq("load_neg", out, 33413);
    apply(1, 1, 0, 0, 0, 0, '0, 0);
    check_eq("hold", out, 33413);

    // 2. Nested call / return.
    do_load(16'd100);
    do_call(16'd500);
    check_eq("call1_depth", depth, 1);
    do_call(16'd900);
    check_eq("call2_out", out, 900);
    do_ret();
    check_eq("ret1_out", out, 501);
    do_ret();
    check_eq("ret2_out", out, 101);
    check_eq("ret2_unf", underflow, 0);

    // 3. Overflow, LIFO drain of the newest entries, then underflow and clr_err.
    do_load(16'd10);
    for (int k = 0; k < 5; k++) do_call(W'(20 + 10 * k));
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_full", full, 1);
    check_eq("ovf_out", out, 60);
    for (int k = 0; k < 4; k++) begin
      do_ret();
      check_eq("drain_out", out, W'(51 - 10 * k));
    end
    do_ret();
    check_eq("unf_hold", out, 21);
    check_eq("unf_flag", underflow, 1);
    apply(1, 1, 0, 0, 0, 0, '0, 1);
    check_eq("clr_ovf", overflow, 0);
    check_eq("clr_unf", underflow, 0);

    // 4. Priority between simultaneous controls.
    do_load(16'd7);
    apply(1, 1, 1, 1, 1, 1, 16'd300, 0);
    check_eq("prio_call", out, 300);
    apply(1, 1, 0, 1, 1, 0, 16'd555, 0);
    check_eq("prio_ret", out, 8);
    apply(1, 1, 0, 0, 1, 1, 16'd12345, 0);
    check_eq("prio_load", out, 12345);
    for (int k = 0; k < 4; k++) do_call(W'(k));
    apply(1, 1, 1, 0, 0, 0, 16'd77, 1);
    check_eq("set_wins", overflow, 1);

    // 5. Enable and reset interaction.
    apply(1, 0, 1, 0, 0, 0, 16'd999, 0);
    check_eq("en0_out", out, 77);
    check_eq("en0_depth", depth, 4);
    apply(0, 0, 0, 0, 0, 0, '0, 0);
    check_eq("en0_rst", out, 0);
    check_eq("en0_rst_ovf", overflow, 0);
    do_call(16'd40);
    do_call(16'd50);
    apply(0, 1, 0, 0, 0, 0, '0, 0);
    check_eq("mid_rst_depth", depth, 0);
    do_ret();
    check_eq("stale_out", out, 0);
    check_eq("stale_unf", underflow, 1);

    // 6. Wrap-around of the increment and of the pushed return address.
    do_load(16'hFFFF);
    do_inc();
    check_eq("wrap_inc", out, 0);
    do_load(16'hFFFF);
    do_call(16'd5);
    do_ret();
    check_eq("wrap_ret", out, 0);

    // Randomized cycles.
    for (int n = 0; n < 400; n++) begin
      rr  = ($urandom_range(0, 40) != 0);
      re  = ($urandom_range(0, 9) != 0);
      rc  = ($urandom_range(0, 3) == 0);
      rrt = ($urandom_range(0, 2) == 0);
      rl  = ($urandom_range(0, 4) == 0);
      ri  = ($urandom_range(0, 1) == 0);
      rcl = ($urandom_range(0, 15) == 0);
      rd  = W'($urandom);
      apply(rr, re, rc, rrt, rl, ri, rd, rcl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
